// File: rtl/iommu_arb_pkg.sv
// Shared types and widths for the IOMMU request arbiter.
package iommu_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} arb_state_t;

  localparam int DVA_W  = 32;
  localparam int PA_W   = 32;
  localparam int STAT_W = 16;

endpackage

// File: rtl/iommu_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module iommu_rr_picker #(
  parameter int NUM_DEV = 4,
  parameter int PTR_W   = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   win_idx,
  output logic [NUM_DEV-1:0] win_oh
);

  localparam logic [PTR_W:0] NUM_DEV_W = (PTR_W+1)'(NUM_DEV);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= NUM_DEV_W)
        sum = sum - NUM_DEV_W;
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_oh = found ? (NUM_DEV'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/iommu_req_arbiter.sv
// Round-robin arbiter sharing one IOMMU translate port among NUM_DEV devices.
// Optional per-device grant/fault counters when IOMMU_ARB_STATS_EN is defined.
module iommu_req_arbiter
  import iommu_arb_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int PTR_W   = $clog2(NUM_DEV)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_DEV-1:0]       dev_req,
  input  logic [NUM_DEV*DVA_W-1:0] dev_addr,
  input  logic [NUM_DEV-1:0]       dev_write_en,
  input  logic [NUM_DEV*32-1:0]    dev_wdata,
  output logic [NUM_DEV-1:0]       dev_ack,
  output logic [NUM_DEV-1:0]       dev_gnt,
  output logic [PA_W-1:0]          dev_paddr,
  output logic [31:0]              dev_rdata,
  output logic                     dev_fault,
  output logic [DVA_W-1:0]         iommu_daddr,
  output logic                     iommu_translate_request,
  output logic                     iommu_write_en,
  output logic [31:0]              iommu_write_data,
  input  logic [PA_W-1:0]          iommu_paddr,
  input  logic [31:0]              iommu_data_out,
  input  logic                     iommu_translation_done,
  input  logic                     iommu_fault
`ifdef IOMMU_ARB_STATS_EN
  ,
  output logic [NUM_DEV*STAT_W-1:0] stat_gnt_cnt,
  output logic [NUM_DEV*STAT_W-1:0] stat_fault_cnt,
  input  logic                      stat_clear
`endif
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_DEV - 1);

  arb_state_t         state, state_nxt;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_DEV-1:0] win_oh;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PA_W-1:0]    cap_paddr;
  logic [31:0]        cap_rdata;
  logic               cap_fault;

  iommu_rr_picker #(
    .NUM_DEV (NUM_DEV),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (dev_req),
    .rr_ptr  (rr_ptr),
    .found   (found),
    .win_idx (win_idx),
    .win_oh  (win_oh)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)                   state_nxt = ISSUE;
      ISSUE:   if (iommu_translation_done)  state_nxt = RELEASE;
      RELEASE: if (!iommu_translation_done) state_nxt = RESP;
      RESP:                                 state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Owner's request fields are latched once at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr                  <= '0;
      gnt_idx                 <= '0;
      dev_gnt                 <= '0;
      dev_ack                 <= '0;
      dev_paddr               <= '0;
      dev_rdata               <= '0;
      dev_fault               <= 1'b0;
      iommu_daddr             <= '0;
      iommu_translate_request <= 1'b0;
      iommu_write_en          <= 1'b0;
      iommu_write_data        <= '0;
      cap_paddr               <= '0;
      cap_rdata               <= '0;
      cap_fault               <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt_idx                 <= win_idx;
          dev_gnt                 <= win_oh;
          iommu_daddr             <= dev_addr[win_idx*DVA_W +: DVA_W];
          iommu_write_en          <= dev_write_en[win_idx];
          iommu_write_data        <= dev_wdata[win_idx*32 +: 32];
          iommu_translate_request <= 1'b1;
        end
        ISSUE: if (iommu_translation_done) begin
          cap_paddr               <= iommu_paddr;
          cap_rdata               <= iommu_data_out;
          cap_fault               <= iommu_fault;
          iommu_translate_request <= 1'b0;
        end
        RELEASE: if (!iommu_translation_done) begin
          dev_ack   <= dev_gnt;
          dev_paddr <= cap_paddr;
          dev_rdata <= cap_rdata;
          dev_fault <= cap_fault;
        end
        RESP: begin
          dev_ack <= '0;
          dev_gnt <= '0;
          rr_ptr  <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IOMMU_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] gnt_cnt   [NUM_DEV];
  logic [STAT_W-1:0] fault_cnt [NUM_DEV];

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_stat
    // Clear takes priority over any increment in the same cycle.
    always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
        gnt_cnt[g]   <= '0;
        fault_cnt[g] <= '0;
      end else begin
        if (state == IDLE && found && win_idx == PTR_W'(g) && gnt_cnt[g] != STAT_MAX)
          gnt_cnt[g] <= gnt_cnt[g] + STAT_W'(1);
        if (state == RESP && cap_fault && gnt_idx == PTR_W'(g) && fault_cnt[g] != STAT_MAX)
          fault_cnt[g] <= fault_cnt[g] + STAT_W'(1);
      end
    end
    assign stat_gnt_cnt[g*STAT_W +: STAT_W]   = gnt_cnt[g];
    assign stat_fault_cnt[g*STAT_W +: STAT_W] = fault_cnt[g];
  end
`endif

endmodule

// File: tb/tb_iommu_req_arbiter.sv
// Directed bench for iommu_req_arbiter with a small behavioural iommu responder.
// Covers the stats ports too when IOMMU_ARB_STATS_EN is defined.
module tb_iommu_req_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   dev_req = '0;
  logic [127:0] dev_addr = '0;
  logic [3:0]   dev_write_en = '0;
  logic [127:0] dev_wdata = '0;
  logic [3:0]   dev_ack, dev_gnt;
  logic [31:0]  dev_paddr, dev_rdata;
  logic         dev_fault;
  logic [31:0]  iommu_daddr;
  logic         iommu_translate_request, iommu_write_en;
  logic [31:0]  iommu_write_data;
  logic [31:0]  iommu_paddr, iommu_data_out;
  logic         iommu_translation_done, iommu_fault;
`ifdef IOMMU_ARB_STATS_EN
  logic [63:0]  stat_gnt_cnt, stat_fault_cnt;
  logic         stat_clear = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] m_data  = 32'h0;
  logic        m_fault = 1'b0;
  int          lat_cnt;

  always #5 clk = ~clk;

  iommu_req_arbiter #(.NUM_DEV(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .dev_req                 (dev_req),
    .dev_addr                (dev_addr),
    .dev_write_en            (dev_write_en),
    .dev_wdata               (dev_wdata),
    .dev_ack                 (dev_ack),
    .dev_gnt                 (dev_gnt),
    .dev_paddr               (dev_paddr),
    .dev_rdata               (dev_rdata),
    .dev_fault               (dev_fault),
    .iommu_daddr             (iommu_daddr),
    .iommu_translate_request (iommu_translate_request),
    .iommu_write_en          (iommu_write_en),
    .iommu_write_data        (iommu_write_data),
    .iommu_paddr             (iommu_paddr),
    .iommu_data_out          (iommu_data_out),
    .iommu_translation_done  (iommu_translation_done),
    .iommu_fault             (iommu_fault)
`ifdef IOMMU_ARB_STATS_EN
    ,
    .stat_gnt_cnt            (stat_gnt_cnt),
    .stat_fault_cnt          (stat_fault_cnt),
    .stat_clear              (stat_clear)
`endif
  );

  // iommu responder: done three cycles into a request, held until the request drops.
  always @(posedge clk) begin
    if (reset) begin
      iommu_translation_done <= 1'b0;
      iommu_paddr            <= '0;
      iommu_data_out         <= '0;
      iommu_fault            <= 1'b0;
      lat_cnt                <= 0;
    end else if (!iommu_translation_done) begin
      if (iommu_translate_request) begin
        if (lat_cnt == 2) begin
          iommu_translation_done <= 1'b1;
          iommu_paddr            <= {20'h12345, iommu_daddr[11:0]};
          iommu_data_out         <= m_data;
          iommu_fault            <= m_fault;
          lat_cnt                <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end else if (!iommu_translate_request) begin
      iommu_translation_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dev_ack != 4'b0) break;
    end
    if (dev_ack == 4'b0) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 4; i++)
        if (dev_ack[i]) idx = i;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    dev_req = '0;
    dev_write_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int idx;
  int order [4];

  initial begin
    // Reset state
    do_reset();
    chk("rst_ack", {28'h0, dev_ack}, 32'h0);
    chk("rst_gnt", {28'h0, dev_gnt}, 32'h0);
    chk("rst_treq", {31'h0, iommu_translate_request}, 32'h0);
    chk("rst_daddr", iommu_daddr, 32'h0);
    chk("rst_paddr", dev_paddr, 32'h0);

    // Single read from dev1
    m_data = 32'hDEADBEEF;
    m_fault = 1'b0;
    dev_addr[32*1 +: 32] = 32'h00401004;
    dev_req[1] = 1'b1;
    @(negedge clk);
    chk("rd_gnt", {28'h0, dev_gnt}, 32'h2);
    chk("rd_treq", {31'h0, iommu_translate_request}, 32'h1);
    chk("rd_daddr", iommu_daddr, 32'h00401004);
    wait_ack(idx);
    chk("rd_ack", {28'h0, dev_ack}, 32'h2);
    chk("rd_paddr", dev_paddr, 32'h12345004);
    chk("rd_rdata", dev_rdata, 32'hDEADBEEF);
    chk("rd_fault", {31'h0, dev_fault}, 32'h0);
    dev_req[1] = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", {28'h0, dev_ack}, 32'h0);
    chk("rd_gnt_clr", {28'h0, dev_gnt}, 32'h0);
    chk("rd_paddr_hold", dev_paddr, 32'h12345004);

    // All four request together from reset
    do_reset();
    for (int k = 0; k < 4; k++)
      dev_addr[32*k +: 32] = 32'h10000000 + 32'(k) * 32'h100;
    dev_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(idx);
      order[k] = idx;
      chk("sim_gnt_at_ack", {28'h0, dev_gnt}, {28'h0, dev_ack});
      chk("sim_paddr", dev_paddr, 32'h12345000 + 32'(k) * 32'h100);
      if (idx >= 0) dev_req[idx] = 1'b0;
    end
    for (int k = 0; k < 4; k++)
      chk("sim_order", order[k], k);

    // Fault on dev2, then a clean dev3 request
    m_fault = 1'b1;
    dev_addr[32*2 +: 32] = 32'h00002008;
    dev_req[2] = 1'b1;
    wait_ack(idx);
    chk("flt_idx", idx, 32'd2);
    chk("flt_fault", {31'h0, dev_fault}, 32'h1);
    dev_req[2] = 1'b0;
    m_fault = 1'b0;
    dev_addr[32*3 +: 32] = 32'h0000300C;
    dev_req[3] = 1'b1;
    wait_ack(idx);
    chk("flt_next_idx", idx, 32'd3);
    chk("flt_next_fault", {31'h0, dev_fault}, 32'h0);
    chk("flt_next_paddr", dev_paddr, 32'h1234500C);
    dev_req[3] = 1'b0;

    // Write from dev0: fields stable from grant until done
    dev_addr[32*0 +: 32]  = 32'h00005000;
    dev_wdata[32*0 +: 32] = 32'hA5A5A5A5;
    dev_write_en[0] = 1'b1;
    dev_req[0] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (iommu_translate_request) begin
        chk("wr_en", {31'h0, iommu_write_en}, 32'h1);
        chk("wr_data", iommu_write_data, 32'hA5A5A5A5);
        chk("wr_daddr", iommu_daddr, 32'h00005000);
      end
      if (dev_ack != 4'b0) break;
    end
    chk("wr_ack", {28'h0, dev_ack}, 32'h1);
    chk("wr_done_low", {31'h0, iommu_translation_done}, 32'h0);
    dev_req[0] = 1'b0;
    dev_write_en[0] = 1'b0;

    // dev0 keeps requesting while dev3 waits
    do_reset();
    dev_req = 4'b1001;
    wait_ack(idx);
    chk("stv_first", idx, 32'd0);
    wait_ack(idx);
    chk("stv_second", idx, 32'd3);
    dev_req[3] = 1'b0;
    wait_ack(idx);
    chk("stv_third", idx, 32'd0);
    dev_req[0] = 1'b0;
    @(negedge clk);

    // Reset in the middle of ISSUE
    dev_addr[32*2 +: 32] = 32'h00007010;
    dev_req[2] = 1'b1;
    @(negedge clk);
    chk("mid_treq", {31'h0, iommu_translate_request}, 32'h1);
    reset = 1'b1;
    dev_req = '0;
    @(negedge clk);
    chk("mid_rst_gnt", {28'h0, dev_gnt}, 32'h0);
    chk("mid_rst_treq", {31'h0, iommu_translate_request}, 32'h0);
    chk("mid_rst_daddr", iommu_daddr, 32'h0);
    chk("mid_rst_paddr", dev_paddr, 32'h0);
`ifdef IOMMU_ARB_STATS_EN
    chk("mid_rst_stat_gnt", stat_gnt_cnt[31:0], 32'h0);
    chk("mid_rst_stat_gnt_hi", stat_gnt_cnt[63:32], 32'h0);
`endif
    reset = 1'b0;
    dev_req[2] = 1'b1;
    wait_ack(idx);
    chk("post_rst_idx", idx, 32'd2);
    chk("post_rst_paddr", dev_paddr, 32'h12345010);
`ifdef IOMMU_ARB_STATS_EN
    chk("post_rst_stat_gnt2", {16'h0, stat_gnt_cnt[47:32]}, 32'h1);
    chk("post_rst_stat_flt2", {16'h0, stat_fault_cnt[47:32]}, 32'h0);
`endif
    dev_req[2] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iommu_req_arbiter.md
Name: iommu_req_arbiter

Overview:
- Shares the single IOMMU translate/access port among NUM_DEV DMA-capable devices using round-robin arbitration.
- Latches the granted device's request and drives the IOMMU's translate_request / translation_done handshake through its full cycle, including the release phase.
- Returns paddr, read data and fault to the granted device with a one-cycle ack pulse.
- Sits between the device fabric and the iommu instance; shares its clk/reset.

Parameters:
- NUM_DEV, 4, number of requesting devices (legal range 2..16).
- PTR_W, $clog2(NUM_DEV), width of the grant index and round-robin pointer (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dev_req  in  NUM_DEV  per-device request; held high until that device's dev_ack
- dev_addr  in  NUM_DEV*32  per-device DVA; slice i = [32*i +: 32]
- dev_write_en  in  NUM_DEV  per-device write flag
- dev_wdata  in  NUM_DEV*32  per-device write data
- dev_ack  out  NUM_DEV  one-hot, one-cycle completion pulse
- dev_gnt  out  NUM_DEV  one-hot, current owner; high from grant through ack
- dev_paddr  out  32  translated physical address; valid with dev_ack
- dev_rdata  out  32  read data; valid with dev_ack when write_en was 0
- dev_fault  out  1  translation fault; valid with dev_ack
- iommu_daddr  out  32  to iommu daddr
- iommu_translate_request  out  1  to iommu translate_request
- iommu_write_en  out  1  to iommu write_en
- iommu_write_data  out  32  to iommu write_data
- iommu_paddr  in  32  from iommu paddr
- iommu_data_out  in  32  from iommu data_out
- iommu_translation_done  in  1  from iommu translation_done
- iommu_fault  in  1  from iommu fault

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr 0, latched request fields 0. Takes effect in any state; the iommu is reset by the same signal.
- Outputs are registered; no combinational path from the device inputs or the iommu inputs to any output.
- IDLE:
  - If any dev_req is set, pick the first set bit searching upward from rr_ptr, with wrap-around.
  - Latch addr, write_en and wdata of the winner into iommu_daddr, iommu_write_en and iommu_write_data.
  - Set dev_gnt[winner] and iommu_translate_request=1; go to ISSUE.
  - Grant occurs one cycle after dev_req is sampled high.
- ISSUE:
  - Hold iommu_translate_request and all latched fields stable.
  - On iommu_translation_done=1: capture iommu_paddr, iommu_data_out and iommu_fault; drop iommu_translate_request; go to RELEASE.
- RELEASE: wait for iommu_translation_done=0 (the iommu returns to its idle state), then go to RESP.
- RESP:
  - Pulse dev_ack[gnt]=1 for exactly one cycle with dev_paddr, dev_rdata and dev_fault valid.
  - Clear dev_gnt; set rr_ptr = (gnt+1) mod NUM_DEV; go to IDLE.
- Device rule: drop dev_req on the edge following dev_ack. A req still high in the next IDLE cycle is a new request.
- Fairness: with all NUM_DEV requesting continuously, grant order is 0,1,2,3,0,...; no device waits more than NUM_DEV-1 transactions.
- dev_paddr, dev_rdata and dev_fault hold their values until the next RESP. dev_rdata is don't-care for writes and when a fault occurs.
- dev_req changes on devices other than the owner during ISSUE, RELEASE or RESP are ignored until IDLE.
- Dropping the owner's dev_req before ack is a protocol violation; the transaction still completes and the ack is still issued.
- Minimum transaction: 4 arbiter cycles plus the iommu latency.

Optional Feature:
- Macro: IOMMU_ARB_STATS_EN.
- When defined, add ports:
  - stat_gnt_cnt  out  NUM_DEV*16
  - stat_fault_cnt  out  NUM_DEV*16
  - stat_clear  in  1
- Counter behaviour:
  - The per-device grant counter increments at each IDLE->ISSUE grant.
  - The per-device fault counter increments at RESP when the captured fault=1.
  - Both saturate at 16'hFFFF.
  - stat_clear zeroes all counters synchronously and wins over a same-cycle increment.
  - Reset clears all counters.
- When undefined: none of these ports or counters exist.

Decomposition:
- Package iommu_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, RELEASE, RESP}.
  - DVA_W=32, PA_W=32, STAT_W=16.
- Sub-module iommu_rr_picker: combinational; inputs req vector and rr_ptr; outputs found and a one-hot/index winner.

Test Plan:
- Single read: dev1 req, addr 0x00401004; iommu model returns paddr 0x12345004, data 0xDEADBEEF -> dev_ack[1] pulse one cycle, dev_paddr=0x12345004, dev_rdata=0xDEADBEEF, dev_fault=0.
- Simultaneous: dev0..dev3 all request from reset -> ack order 0,1,2,3; each device's dev_gnt stays high until its ack.
- Fault: dev2 req; iommu model asserts fault with done -> dev_ack[2] with dev_fault=1; the following request from dev3 sees dev_fault=0.
- Write: dev0 write_en=1, wdata 0xA5A5A5A5 -> iommu_write_en=1 and iommu_write_data=0xA5A5A5A5 stable from grant until done; ack follows after done falls.
- Starvation: dev0 re-requests immediately after each ack while dev3 is requesting -> dev3 granted after dev0 (rr_ptr=1 skips 1,2).
- Reset during ISSUE -> next cycle all outputs 0; post-reset request from dev2 completes normally. With IOMMU_ARB_STATS_EN, counters read 0 after the reset and then 1 grant for dev2.
